// File: rtl/arb_pkg.sv
// Shared constants and types for the 16-way round-robin arbiter.
package arb_pkg;
  localparam int N   = 16;
  localparam int IDW = 4;
  localparam int HCW = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    return N'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick16.sv
// Rotating-priority pick: first set request at or after start, wrapping mod 16.
module rr_pick16
  import arb_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [IDW-1:0] idx,
  output logic           none
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;

  // Rotate so that 'start' lands on bit 0, then take the lowest set bit.
  always_comb begin
    rot = N'({req, req} >> start);
    off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
  end

  assign none = ~|req;
  assign idx  = none ? '0 : start + off;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with grant hold and hold-limit preemption.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           idle,
  output logic           preempt
);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick;
  logic           pick_none;
  logic [HCW-1:0] hold_cnt;
  logic           rel;
  logic           expd;

  rr_pick16 u_pick (
    .req   (req),
    .start (ptr),
    .idx   (pick),
    .none  (pick_none)
  );

  assign rel  = done | ~req[gnt_id];
  assign expd = (hold_cnt == HCW'(MAX_HOLD - 1));
  assign idle = (state == ST_IDLE) & pick_none;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          preempt <= 1'b0;
          if (!pick_none) begin
            state     <= ST_GRANT;
            gnt_id    <= pick;
            gnt       <= onehot(pick);
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          // A release in the expiry cycle wins: no preempt pulse then.
          if (rel || expd) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 4'd1;
            preempt   <= expd & ~rel;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
            preempt  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 (MAX_HOLD=8 and MAX_HOLD=1 instances).
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;

  logic [15:0] gnt0, gnt1;
  logic [3:0]  id0, id1;
  logic        vld0, vld1, idle0, idle1, pre0, pre1;

  rr_arbiter16 #(.MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt0), .gnt_id(id0), .gnt_valid(vld0), .idle(idle0), .preempt(pre0)
  );

  rr_arbiter16 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(vld1), .idle(idle1), .preempt(pre1)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs before the edge, expected outputs after it.
  typedef struct {
    logic [15:0] req;
    logic        done;
    int          owner;   // -1 = no grant
    logic        pre;
    logic        idl;
  } vec_t;

  vec_t tab_main[$];
  vec_t tab_h1[$];
  vec_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int stepno   = 0;
  int sel      = 0;

  function automatic vec_t mk(logic [15:0] r, logic d, int o, logic p, logic i);
    vec_t v;
    v.req = r; v.done = d; v.owner = o; v.pre = p; v.idl = i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, stepno, got, want);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t        e;
    logic [15:0] g;
    logic [3:0]  id;
    logic        vl, pr, il;
    req  = v.req;
    done = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    stepno++;
    e  = exp_q.pop_front();
    g  = (sel != 0) ? gnt1  : gnt0;
    id = (sel != 0) ? id1   : id0;
    vl = (sel != 0) ? vld1  : vld0;
    pr = (sel != 0) ? pre1  : pre0;
    il = (sel != 0) ? idle1 : idle0;
    chk("gnt", 32'(g), (e.owner >= 0) ? (32'd1 << e.owner) : 32'd0);
    chk("gnt_valid", 32'(vl), (e.owner >= 0) ? 32'd1 : 32'd0);
    if (e.owner >= 0) chk("gnt_id", 32'(id), 32'(e.owner));
    chk("preempt", 32'(pr), 32'(e.pre));
    chk("idle", 32'(il), 32'(e.idl));
    chk("onehot0", 32'($onehot0(g)), 32'd1);
  endtask

  task automatic run(input vec_t t[$]);
    for (int i = 0; i < t.size(); i++) step(t[i]);
  endtask

  initial begin
    // Reset release, rotation 0/5, wrap-around, drop release.
    tab_main.push_back(mk(16'hFFFF, 0,  0, 0, 0));
    tab_main.push_back(mk(16'h0021, 1, -1, 0, 0));
    for (int r = 0; r < 2; r++) begin
      tab_main.push_back(mk(16'h0021, 0,  5, 0, 0));
      tab_main.push_back(mk(16'h0021, 0,  5, 0, 0));
      tab_main.push_back(mk(16'h0021, 1, -1, 0, 0));
      if (r == 0) begin
        tab_main.push_back(mk(16'h0021, 0,  0, 0, 0));
        tab_main.push_back(mk(16'h0021, 0,  0, 0, 0));
        tab_main.push_back(mk(16'h0021, 1, -1, 0, 0));
      end
    end
    tab_main.push_back(mk(16'h0000, 0, -1, 0, 1));
    tab_main.push_back(mk(16'h2000, 0, 13, 0, 0));
    tab_main.push_back(mk(16'h2000, 1, -1, 0, 0));
    tab_main.push_back(mk(16'h2100, 0,  8, 0, 0));
    tab_main.push_back(mk(16'h2100, 1, -1, 0, 0));
    tab_main.push_back(mk(16'h2100, 0, 13, 0, 0));
    tab_main.push_back(mk(16'h0000, 0, -1, 0, 1));
    // Hold-limit expiry, then release on the expiry cycle.
    tab_main.push_back(mk(16'h0080, 0,  7, 0, 0));
    for (int k = 0; k < 7; k++) tab_main.push_back(mk(16'h0080, 0, 7, 0, 0));
    tab_main.push_back(mk(16'h0080, 0, -1, 1, 0));
    tab_main.push_back(mk(16'h0080, 0,  7, 0, 0));
    for (int k = 0; k < 7; k++) tab_main.push_back(mk(16'h0080, 0, 7, 0, 0));
    tab_main.push_back(mk(16'h0080, 1, -1, 0, 0));
    tab_main.push_back(mk(16'h0180, 0,  8, 0, 0));
    tab_main.push_back(mk(16'h0200, 0, -1, 0, 0));
    tab_main.push_back(mk(16'h0200, 0,  9, 0, 0));
    tab_main.push_back(mk(16'h0200, 0,  9, 0, 0));

    // MAX_HOLD=1 instance, starting from ptr=1 in IDLE.
    tab_h1.push_back(mk(16'h0003, 0,  1, 0, 0));
    tab_h1.push_back(mk(16'h0003, 0, -1, 1, 0));
    tab_h1.push_back(mk(16'h0003, 0,  0, 0, 0));
    tab_h1.push_back(mk(16'h0003, 0, -1, 1, 0));
    tab_h1.push_back(mk(16'h0003, 0,  1, 0, 0));
    tab_h1.push_back(mk(16'h0003, 1, -1, 0, 0));
    tab_h1.push_back(mk(16'h0000, 0, -1, 0, 1));

    rst_n = 1'b0;
    done  = 1'b0;
    req   = 16'h0000;
    #1;
    chk("reset_idle_noreq", 32'(idle0), 32'd1);
    req = 16'hFFFF;
    #1;
    chk("reset_gnt", 32'(gnt0), 32'd0);
    chk("reset_gnt_valid", 32'(vld0), 32'd0);
    chk("reset_gnt_id", 32'(id0), 32'd0);
    chk("reset_preempt", 32'(pre0), 32'd0);
    chk("reset_idle_req", 32'(idle0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(tab_main);

    // Asynchronous reset while requester 9 holds the grant.
    #2;
    rst_n = 1'b0;
    req   = 16'h0201;
    #1;
    chk("async_gnt", 32'(gnt0), 32'd0);
    chk("async_gnt_valid", 32'(vld0), 32'd0);
    chk("async_preempt", 32'(pre0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(16'h0201, 0,  0, 0, 0));
    step(mk(16'h0000, 0, -1, 0, 1));

    sel = 1;
    run(tab_h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Uses a rotating-priority pick (16-bit request vector, 4-bit start index, 4-bit index out, zero flag) to choose the next owner.
- Holds the grant until release, request drop, or hold-limit expiry, then advances the priority pointer.
- Sits between the requesters and the shared resource's select mux.

Parameters:
- N, 16, number of requesters (fixed at 16; index width 4).
- MAX_HOLD, 8, max cycles one grant may be held; legal 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  16  request vector; bit i = requester i.
- done  in  1  current owner releases resource (single-cycle pulse, honoured only in GRANT).
- gnt  out  16  one-hot grant, registered.
- gnt_id  out  4  index of current owner; valid when gnt_valid=1.
- gnt_valid  out  1  a grant is active.
- idle  out  1  high in IDLE with req==0 (no pending work).
- preempt  out  1  one-cycle pulse when a grant is revoked by hold-limit expiry.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0, idle=1.
  - Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- Pick function (combinational):
  - pick = first i with req[i]=1, searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - any = |req.
- States: IDLE, GRANT.
- IDLE:
  - If any=1: next edge goes to GRANT with gnt_id<=pick, gnt<=1<<pick, gnt_valid<=1, hold_cnt<=0.
  - Latency: req asserted before edge k gives gnt high after edge k (1 cycle).
  - If any=0: stay in IDLE, outputs 0.
- GRANT, evaluated each cycle:
  - rel = done | ~req[gnt_id].
  - exp = (hold_cnt == MAX_HOLD-1).
  - If rel or exp:
    - next edge goes to IDLE; gnt, gnt_valid <= 0.
    - ptr <= gnt_id+1 (4-bit wrap, 15->0).
    - preempt <= exp & ~rel.
  - Otherwise hold_cnt <= hold_cnt+1 and the grant is unchanged.
- Simultaneous events:
  - rel and exp in the same cycle: counts as a normal release, no preempt pulse.
- Gaps and timing:
  - Between consecutive owners gnt is 0 for exactly one cycle (the IDLE cycle).
  - Arbitration in that IDLE cycle already uses the updated ptr.
  - A requester holding req continuously is re-granted at most once per rotation when others are requesting.
- Ignored inputs:
  - done in IDLE is ignored.
  - Requests changing during GRANT do not alter the owner.
- preempt:
  - Registered; high exactly one cycle, coincident with the IDLE gap cycle.
- Hold limit:
  - MAX_HOLD=1: every grant lasts exactly one cycle, and preempt fires unless a release occurs in that same cycle.
- idle:
  - idle = (state==IDLE) & ~any; combinational output.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt == (gnt_valid ? 1<<gnt_id : 0).

Decomposition:
- Package arb_pkg:
  - localparams N=16, IDW=4.
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Hold-counter width 8.
- Sub-module rr_pick16:
  - Combinational rotating-priority pick.
  - Ports: req[15:0], start[3:0] -> idx[3:0], none (1 when req==0; idx=0 then).
  - Instantiated once with start=ptr.
- FSM, pointer and hold counter stay in rr_arbiter16.

Test Plan:
- Reset: rst_n=0 with req=16'hFFFF -> gnt=0, gnt_valid=0, idle=0. Release reset -> after 1 edge gnt_id=0, gnt=16'h0001.
- Rotation: req=16'h0021 held, done pulsed 1 cycle after each grant -> owners 0,5,0,5 with one zero-gnt cycle between each; ptr after first release = 1.
- Wrap-around: ptr driven to 14 via grant/release of 13, then req=16'h2100 -> grant 8 (search 14,15,0..8). After release, ptr=9, so next grant is 13.
- Preemption: MAX_HOLD=8, req=16'h0080 held, no done -> gnt_id=7 for exactly 8 cycles, then 1 gap cycle with preempt=1, then re-granted to 7.
- Simultaneous release/expiry: done asserted on the 8th hold cycle -> preempt stays 0, ptr advances to owner+1.
- Async reset mid-grant: rst_n low between edges while gnt=16'h0200 -> gnt=0 immediately. After release, arbitration restarts from ptr=0.
